ones_frame_acc: RTL and testbench
=================================

ONES_FRAME_ACC -- requirements
Module: ones_frame_acc

Interface
REQ-001 Parameter FRAME_LEN, default 8: number of count beats per frame; legal range 1..255.
REQ-002 Parameter SUM_W, default 7: width of the frame total.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to open a new frame.
REQ-006 count  input  4  per-byte ones count from the upstream popcount stage; legal 0..8.
REQ-007 in_valid  input  1  count is valid this cycle.
REQ-008 in_ready  output  1  block accepts count this cycle.
REQ-009 total  output  SUM_W  frame sum of accepted counts.
REQ-010 max_cnt  output  4  largest count accepted in the frame.
REQ-011 sat  output  1  total saturated during the frame.
REQ-012 err  output  1  an illegal count (>8) was accepted during the frame.
REQ-013 out_valid  output  1  frame result is valid.
REQ-014 out_ready  input  1  downstream consumes the result.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACC and HOLD.
REQ-016 In IDLE, in_ready=0 and out_valid=0; start=1 SHALL move the FSM to ACC and clear the sum, max_cnt, sat, err and the beat counter.
REQ-017 In ACC, in_ready SHALL be 1 combinationally; a beat is accepted when in_valid and in_ready are both 1 at a clock edge.
REQ-018 Each accepted beat SHALL add count, zero-extended, to the sum and SHALL increment the beat counter.
REQ-019 If the addition exceeds 2^SUM_W-1, the sum SHALL hold at 2^SUM_W-1 and sat SHALL be set; sat remains set until the next frame opens.
REQ-020 An accepted count >8 SHALL still be added to the sum and SHALL set err for the remainder of the frame.
REQ-021 max_cnt SHALL update to count whenever an accepted count exceeds the current max_cnt.
REQ-022 On acceptance of beat FRAME_LEN, the FSM SHALL enter HOLD.
REQ-023 out_valid SHALL be 1 in the first HOLD cycle, i.e. one cycle after the last beat is accepted.
REQ-024 In HOLD, in_ready=0, and total, max_cnt, sat and err SHALL remain stable while out_valid=1.
REQ-025 In HOLD, out_ready=1 SHALL complete the transfer; the next state is ACC with cleared accumulators if start=1 in the same cycle, otherwise IDLE.
REQ-026 start SHALL be ignored in ACC, and in HOLD unless it coincides with out_ready=1.
REQ-027 in_valid SHALL be ignored outside ACC; no beat is consumed.
REQ-028 total, max_cnt, sat and err SHALL hold their last frame values in IDLE; they clear only when a new frame opens.
REQ-029 in_valid gaps in ACC SHALL only stall the block; a frame of FRAME_LEN beats completes regardless of the number of idle cycles.

Reset
REQ-030 On rst_n=0 at a clock edge, the FSM SHALL go to IDLE and total=0, max_cnt=0, sat=0, err=0, out_valid=0, in_ready=0 and beat counter=0.
REQ-031 Reset SHALL take priority over all other inputs in any state, including mid-frame in ACC and in HOLD with out_valid=1; the partial frame is discarded.
REQ-032 No output SHALL change asynchronously to clk because of rst_n.

Verification
REQ-033 Defaults; start pulse, then counts 1,2,3,4,5,6,7,8 with in_valid held high -> out_valid one cycle after the 8th beat, total=36, max_cnt=8, sat=0, err=0.
REQ-034 Defaults; eight counts of 8 with in_valid toggling every other cycle and out_ready low for 5 cycles -> total=64, outputs stable through the stall, IDLE after out_ready.
REQ-035 SUM_W=5; eight counts of 8 -> total=31, sat=1; the next frame opens with sat=0.
REQ-036 Defaults; frame containing count=9 and seven counts of 0 -> total=9, err=1, max_cnt=9.
REQ-037 rst_n low after 3 of 8 beats, then a new start -> all outputs 0 during reset; the new frame totals only post-reset beats.
REQ-038 out_ready and start both high in HOLD -> the FSM goes directly to ACC, accumulators clear, and in_ready=1 on the next cycle.

Source files
------------

// File: rtl/ones_frame_acc.sv
// Frame accumulator for per-byte popcounts: sums FRAME_LEN accepted beats,
// tracks the largest count, saturation and illegal counts, then holds the result.
module ones_frame_acc #(
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       count,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SUM_W-1:0] total,
  output logic [3:0]       max_cnt,
  output logic             sat,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } state_t;

  localparam int AW = SUM_W + 5;
  localparam logic [SUM_W-1:0] SMAX = '1;

  state_t           r_state;
  logic [7:0]       r_beats;
  logic [SUM_W-1:0] r_total;
  logic [3:0]       r_max;
  logic             r_sat;
  logic             r_err;
  logic             r_ov;

  logic [AW-1:0]    w_add;
  logic             w_ovf;
  logic             w_accept;
  logic             w_last;

  // Widened add so an overflow past the top of the sum is visible.
  assign w_add    = AW'(r_total) + AW'(count);
  assign w_ovf    = w_add > AW'(SMAX);
  assign w_accept = in_valid && (r_state == S_ACC);
  assign w_last   = (r_beats == 8'(FRAME_LEN - 1));

  assign in_ready  = (r_state == S_ACC);
  assign total     = r_total;
  assign max_cnt   = r_max;
  assign sat       = r_sat;
  assign err       = r_err;
  assign out_valid = r_ov;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_beats <= '0;
      r_total <= '0;
      r_max   <= '0;
      r_sat   <= 1'b0;
      r_err   <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ACC;
            r_beats <= '0;
            r_total <= '0;
            r_max   <= '0;
            r_sat   <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        S_ACC: begin
          if (w_accept) begin
            r_total <= w_ovf ? SMAX : w_add[SUM_W-1:0];
            r_beats <= r_beats + 8'd1;
            if (w_ovf)
              r_sat <= 1'b1;
            if (count > 4'd8)
              r_err <= 1'b1;
            if (count > r_max)
              r_max <= count;
            if (w_last) begin
              r_state <= S_HOLD;
              r_ov    <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_ov <= 1'b0;
            // Back-to-back frame: reopen directly without visiting IDLE.
            if (start) begin
              r_state <= S_ACC;
              r_beats <= '0;
              r_total <= '0;
              r_max   <= '0;
              r_sat   <= 1'b0;
              r_err   <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ov    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ones_frame_acc.sv
// Randomised bench for ones_frame_acc: two instances (SUM_W=7 and SUM_W=5)
// share stimulus and are checked against a frame-level reference model.
module tb_ones_frame_acc;

  localparam int FL = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] count = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       ir_a, ir_b;
  logic [6:0] tot_a;
  logic [4:0] tot_b;
  logic [3:0] max_a, max_b;
  logic       sat_a, sat_b;
  logic       err_a, err_b;
  logic       ov_a, ov_b;

  int n_pass = 0;
  int n_tot  = 0;
  int beats[FL];
  bit in_acc = 0;

  always #5 clk = ~clk;

  ones_frame_acc #(.FRAME_LEN(FL), .SUM_W(7)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count),
    .in_valid(in_valid), .in_ready(ir_a), .total(tot_a),
    .max_cnt(max_a), .sat(sat_a), .err(err_a),
    .out_valid(ov_a), .out_ready(out_ready)
  );

  ones_frame_acc #(.FRAME_LEN(FL), .SUM_W(5)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count),
    .in_valid(in_valid), .in_ready(ir_b), .total(tot_b),
    .max_cnt(max_b), .sat(sat_b), .err(err_b),
    .out_valid(ov_b), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Expected frame result straight from the beat list.
  task automatic chk_result(input string tag, input int ov, input int ir);
    int s = 0;
    int m = 0;
    int e = 0;
    for (int i = 0; i < FL; i++) begin
      s += beats[i];
      if (beats[i] > m) m = beats[i];
      if (beats[i] > 8) e = 1;
    end
    chk({tag, " total7"}, tot_a, (s > 127) ? 127 : s);
    chk({tag, " sat7"}, sat_a, (s > 127) ? 1 : 0);
    chk({tag, " total5"}, tot_b, (s > 31) ? 31 : s);
    chk({tag, " sat5"}, sat_b, (s > 31) ? 1 : 0);
    chk({tag, " max7"}, max_a, m);
    chk({tag, " max5"}, max_b, m);
    chk({tag, " err7"}, err_a, e);
    chk({tag, " err5"}, err_b, e);
    chk({tag, " ov7"}, ov_a, ov);
    chk({tag, " ov5"}, ov_b, ov);
    chk({tag, " ir7"}, ir_a, ir);
    chk({tag, " ir5"}, ir_b, ir);
  endtask

  task automatic chk_zero(input string tag, input int ir);
    chk({tag, " total7"}, tot_a, 0);
    chk({tag, " total5"}, tot_b, 0);
    chk({tag, " max7"}, max_a, 0);
    chk({tag, " sat5"}, sat_b, 0);
    chk({tag, " err7"}, err_a, 0);
    chk({tag, " ov7"}, ov_a, 0);
    chk({tag, " ov5"}, ov_b, 0);
    chk({tag, " ir7"}, ir_a, ir);
    chk({tag, " ir5"}, ir_b, ir);
  endtask

  task automatic rand_beats();
    for (int i = 0; i < FL; i++)
      beats[i] = ($urandom_range(0, 9) == 0) ?
                 int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
  endtask

  task automatic open_frame(input string tag);
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b1;
    count = 4'd5;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    chk_zero({tag, " open"}, 1);
    in_acc = 1;
  endtask

  // mode 0: in_valid held, 1: toggling, 2: random gaps
  task automatic feed(input int n, input int mode);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < n && cyc < 1000) begin
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 2) == 0;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      count = 4'(beats[idx]);
      start = ($urandom_range(0, 3) == 0);
      acc = in_valid && ir_a;
      @(negedge clk);
      if (acc) idx++;
      cyc++;
    end
    if (cyc >= 1000) chk("feed timeout", idx, n);
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic finish(input string tag, input int stall, input bit chain);
    chk_result({tag, " hold"}, 1, 0);
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      start = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      count = 4'($urandom_range(0, 15));
      @(negedge clk);
      chk_result({tag, " stall"}, 1, 0);
    end
    out_ready = 1'b1;
    start = chain;
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    if (chain) begin
      chk_zero({tag, " chain"}, 1);
    end else begin
      chk_result({tag, " idle"}, 0, 0);
      in_valid = 1'b1;
      count = 4'd7;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      chk_result({tag, " idle hold"}, 0, 0);
    end
    in_acc = chain;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset", 0);
    rst_n = 1'b1;

    for (int i = 0; i < FL; i++) beats[i] = i + 1;
    open_frame("f1");
    feed(FL, 0);
    finish("f1", 0, 0);

    for (int i = 0; i < FL; i++) beats[i] = 8;
    open_frame("f2");
    feed(FL, 1);
    finish("f2", 5, 0);

    for (int i = 0; i < FL; i++) beats[i] = 0;
    beats[3] = 9;
    open_frame("f3");
    feed(FL, 2);
    finish("f3", 2, 1);

    rand_beats();
    feed(FL, 2);
    finish("f4", 1, 0);

    rand_beats();
    open_frame("f5");
    feed(3, 0);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk_zero("rst acc", 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_zero("post rst", 0);
    open_frame("f6");
    feed(FL, 0);
    chk_result("f6 hold", 1, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("rst hold", 0);
    rst_n = 1'b1;

    for (int f = 0; f < 12; f++) begin
      rand_beats();
      if (!in_acc) open_frame("rnd");
      feed(FL, int'($urandom_range(0, 2)));
      finish("rnd", int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
